unreg_bank: RTL and testbench
=============================

# unreg_bank

Registered, parametrised successor to the combinational `unreg` next-state slice. It holds `DEPTH` words of `WIDTH` bits and applies the same load / load-inverted / set / clear update per word through a valid/ready write port. It adds a multi-cycle sweep that fills the whole bank, and a registered read port with optional output inversion. It sits between the control decode and the datapath outputs, where `unreg` previously drove outputs directly.

## Interface
- `WIDTH`, 16, bits per word (≥1)
- `DEPTH`, 4, words in bank (≥2, power of two)
- `INVERT_OUT`, 1, 1: `prd_data` is the bitwise complement of the stored word; 0: true value
- `AW`, $clog2(DEPTH), address width (derived, not overridable)

Ports (clock and reset first):
- `pclk`  in  1  sole clock, rising edge
- `prst`  in  1  asynchronous, active-high reset
- `pwr_valid`  in  1  write request
- `pwr_ready`  out  1  write accepted when valid & ready
- `pwr_addr`  in  AW  write word index
- `pwr_mode`  in  2  00 load A, 01 load ~B, 10 set all-ones, 11 clear
- `pwr_a`  in  WIDTH  data for mode 00
- `pwr_b`  in  WIDTH  data for mode 01
- `psweep`  in  1  start bank fill, single-cycle pulse
- `pswp_val`  in  WIDTH  fill value, sampled on the `psweep` start cycle
- `pbusy`  out  1  sweep in progress
- `prd_en`  in  1  read request
- `prd_addr`  in  AW  read word index
- `prd_valid`  out  1  read data valid
- `prd_data`  out  WIDTH  read data

## Operation
- FSM states: IDLE and SWEEP.
- IDLE to SWEEP on `psweep`=1. The cycle that accepts `psweep` latches `pswp_val` and sets the sweep pointer to 0.
- In SWEEP, one word is written per cycle at the pointer, from 0 to DEPTH-1. The state returns to IDLE after word DEPTH-1 is written, so the sweep lasts exactly DEPTH cycles.
- `pwr_ready` = (state==IDLE) & ~`psweep`. A write presented in the same cycle as `psweep` is not accepted; the sweep wins.
- `psweep` is ignored during SWEEP.
- `pbusy` = (state==SWEEP).
- An accepted write updates word `pwr_addr` at the next edge: mode 00 stores A, mode 01 stores ~B, mode 10 stores all-ones, mode 11 stores zero.
- Reads are allowed in any state. `prd_data` is registered.
- Write-first forwarding: if the read address equals the address being written this cycle (an accepted write or a sweep write), `prd_data` returns the new value.
- Output transform: `prd_data` = `INVERT_OUT` ? ~word : word.
- `prd_valid` is `prd_en` delayed by one cycle. `prd_data` holds its value when `prd_en`=0.

## Timing
- Reset values: all words 0, state IDLE, pointer 0, `pwr_ready`=1, `pbusy`=0, `prd_valid`=0, `prd_data`=0 (independent of `INVERT_OUT`).
- Write latency: 1 edge. Read latency: 1 cycle.
- `psweep` at cycle t: `pbusy`=1 for cycles t+1 .. t+DEPTH, and `pwr_ready` returns to 1 at t+DEPTH+1. Word k is written at the edge ending cycle t+1+k.
- An asserted `prst` during SWEEP aborts the sweep immediately. All words return to 0 and no partial fill is retained.
- There is no backpressure on reads.

## Structure
- Shared package `unreg_pkg`:
  - `wr_mode_t` enum: LOAD_A, LOAD_NB, SET, CLR
  - `bank_state_t` enum: IDLE, SWEEP
- Sub-module `unreg_next`: combinational next-word function of (mode, A, B) → WIDTH bits. It is reused for both the sweep path and the write path; the sweep drives it as LOAD_A with `pswp_val`.
- The top level holds the storage array, FSM, pointer, forwarding compare and read register.

## Test plan
- Reset then read: with `INVERT_OUT`=1, read address 2 → `prd_valid`=1 one cycle later, `prd_data`=16'hFFFF.
- Writes: write 16'h1234 mode 00 to address 1, then 16'h00FF mode 01 to address 3. Reads return ~16'h1234=16'hEDCB and ~16'hFF00=16'h00FF.
- Forwarding: write mode 10 to address 0 and read address 0 in the same cycle → next cycle `prd_data`=16'h0000 (`INVERT_OUT`=1).
- Sweep: `psweep` with `pswp_val`=16'hA5A5 and DEPTH=4 → `pbusy` high for 4 cycles and `pwr_ready` low for 4 cycles. A write offered mid-sweep is held off. All reads afterwards return 16'h5A5A.
- Collision and abort: `psweep` together with `pwr_valid` → write not accepted. Assert `prst` at sweep cycle 2 → all reads return 16'hFFFF, `pbusy`=0.

Source files
------------

// File: rtl/unreg_pkg.sv
// unreg_pkg: shared types for the unreg word update and the bank FSM
// wr_mode_t    : per-word update selector (matches the 2-bit pwr_mode encoding)
// bank_state_t : bank controller states
package unreg_pkg;
   typedef enum logic [1:0] {LOAD_A, LOAD_NB, SET, CLR} wr_mode_t;
   typedef enum logic [0:0] {IDLE, SWEEP} bank_state_t;
endpackage

// File: rtl/unreg_next.sv
// unreg_next: combinational next-word function, shared by the write and sweep paths
// mode : update selector
// a, b : operands for LOAD_A and LOAD_NB
// y    : resulting word
module unreg_next
   import unreg_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  wr_mode_t           mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [WIDTH-1:0]   y
);
   always_comb
      y = mode == LOAD_A  ? a  :
          mode == LOAD_NB ? ~b :
          mode == SET     ? '1 : '0;
endmodule

// File: rtl/unreg_bank.sv
// unreg_bank: registered DEPTH x WIDTH word bank with unreg-style writes, fill sweep and registered read
// pclk, prst                       : clock, asynchronous active-high reset
// pwr_valid/ready/addr/mode/a/b    : valid/ready write port
// psweep, pswp_val, pbusy          : bank fill start pulse, fill value, sweep in progress
// prd_en, prd_addr                 : read request
// prd_valid, prd_data              : registered read result, optionally inverted
module unreg_bank
   import unreg_pkg::*;
#(
   parameter  int WIDTH      = 16,
   parameter  int DEPTH      = 4,
   parameter  bit INVERT_OUT = 1,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic              pclk,
   input  logic              prst,
   input  logic              pwr_valid,
   output logic              pwr_ready,
   input  logic [AW-1:0]     pwr_addr,
   input  logic [1:0]        pwr_mode,
   input  logic [WIDTH-1:0]  pwr_a,
   input  logic [WIDTH-1:0]  pwr_b,
   input  logic              psweep,
   input  logic [WIDTH-1:0]  pswp_val,
   output logic              pbusy,
   input  logic              prd_en,
   input  logic [AW-1:0]     prd_addr,
   output logic              prd_valid,
   output logic [WIDTH-1:0]  prd_data
);
   bank_state_t       state;
   logic [AW-1:0]     ptr;
   logic [WIDTH-1:0]  swp_val;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic              we;
   logic [AW-1:0]     waddr;
   logic [WIDTH-1:0]  nxt;
   logic [WIDTH-1:0]  rd_word;
   wr_mode_t          mode;
   logic [WIDTH-1:0]  op_a;
   // one next-word instance serves both paths; the sweep is a LOAD_A of the latched fill value
   always_comb begin
      pbusy     = state == SWEEP;
      pwr_ready = state == IDLE && !psweep;
      we        = pbusy || (pwr_valid && pwr_ready);
      waddr     = pbusy ? ptr : pwr_addr;
      mode      = pbusy ? LOAD_A : wr_mode_t'(pwr_mode);
      op_a      = pbusy ? swp_val : pwr_a;
      rd_word   = (we && waddr == prd_addr) ? nxt : mem[prd_addr];
   end
   unreg_next #(.WIDTH(WIDTH)) u_next (
      .mode (mode),
      .a    (op_a),
      .b    (pwr_b),
      .y    (nxt)
   );
   always_ff @(posedge pclk or posedge prst)
      if (prst) begin
         state   <= IDLE;
         ptr     <= '0;
         swp_val <= '0;
      end else if (state == IDLE && psweep) begin
         state   <= SWEEP;
         ptr     <= '0;
         swp_val <= pswp_val;
      end else if (pbusy) begin
         state   <= ptr == AW'(DEPTH - 1) ? IDLE : SWEEP;
         ptr     <= ptr + 1'b1;
      end
   always_ff @(posedge pclk or posedge prst)
      if (prst)
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      else if (we)
         mem[waddr] <= nxt;
   always_ff @(posedge pclk or posedge prst)
      if (prst) begin
         prd_valid <= 1'b0;
         prd_data  <= '0;
      end else begin
         prd_valid <= prd_en;
         if (prd_en) prd_data <= INVERT_OUT ? ~rd_word : rd_word;
      end
endmodule

// File: tb/tb_unreg_bank.sv
// tb_unreg_bank: directed self-checking bench for unreg_bank (WIDTH 16, DEPTH 4, INVERT_OUT 1)
module tb_unreg_bank;
   logic        pclk = 1'b0;
   logic        prst = 1'b1;
   logic        pwr_valid = 1'b0;
   logic        pwr_ready;
   logic [1:0]  pwr_addr = '0;
   logic [1:0]  pwr_mode = '0;
   logic [15:0] pwr_a = '0;
   logic [15:0] pwr_b = '0;
   logic        psweep = 1'b0;
   logic [15:0] pswp_val = '0;
   logic        pbusy;
   logic        prd_en = 1'b0;
   logic [1:0]  prd_addr = '0;
   logic        prd_valid;
   logic [15:0] prd_data;
   int          n_pass = 0;
   int          n_chk = 0;
   unreg_bank #(.WIDTH(16), .DEPTH(4), .INVERT_OUT(1)) dut (
      .pclk      (pclk),
      .prst      (prst),
      .pwr_valid (pwr_valid),
      .pwr_ready (pwr_ready),
      .pwr_addr  (pwr_addr),
      .pwr_mode  (pwr_mode),
      .pwr_a     (pwr_a),
      .pwr_b     (pwr_b),
      .psweep    (psweep),
      .pswp_val  (pswp_val),
      .pbusy     (pbusy),
      .prd_en    (prd_en),
      .prd_addr  (prd_addr),
      .prd_valid (prd_valid),
      .prd_data  (prd_data)
   );
   always #5 pclk = ~pclk;
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   task automatic tick;
      @(posedge pclk);
      #1;
   endtask
   task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string tag);
      prd_en = 1'b1;
      prd_addr = a;
      tick();
      prd_en = 1'b0;
      check({tag, "_valid"}, 16'(prd_valid), 16'h0001);
      check(tag, prd_data, exp);
   endtask
   task automatic wr(input logic [1:0] a, input logic [1:0] m, input logic [15:0] da, input logic [15:0] db);
      pwr_valid = 1'b1;
      pwr_addr = a;
      pwr_mode = m;
      pwr_a = da;
      pwr_b = db;
      tick();
      pwr_valid = 1'b0;
   endtask
   initial begin
      tick();
      tick();
      check("rst_ready", 16'(pwr_ready), 16'h0001);
      check("rst_busy", 16'(pbusy), 16'h0000);
      check("rst_valid", 16'(prd_valid), 16'h0000);
      check("rst_data", prd_data, 16'h0000);
      prst = 1'b0;
      tick();
      rd(2'd2, 16'hFFFF, "rd_reset");
      tick();
      check("rd_idle_valid", 16'(prd_valid), 16'h0000);
      check("rd_hold", prd_data, 16'hFFFF);
      wr(2'd1, 2'b00, 16'h1234, 16'h0000);
      wr(2'd3, 2'b01, 16'h0000, 16'h00FF);
      rd(2'd1, 16'hEDCB, "rd_load_a");
      rd(2'd3, 16'h00FF, "rd_load_nb");
      // write SET to word 0 while reading it: forwarded value is all-ones, inverted to zero
      pwr_valid = 1'b1;
      pwr_addr = 2'd0;
      pwr_mode = 2'b10;
      rd(2'd0, 16'h0000, "fwd_set");
      pwr_valid = 1'b0;
      rd(2'd0, 16'h0000, "rd_set");
      wr(2'd1, 2'b11, 16'h0000, 16'h0000);
      rd(2'd1, 16'hFFFF, "rd_clr");
      // sweep start colliding with a write to word 2
      psweep = 1'b1;
      pswp_val = 16'hA5A5;
      pwr_valid = 1'b1;
      pwr_addr = 2'd2;
      pwr_mode = 2'b00;
      pwr_a = 16'h1111;
      #1;
      check("swp_start_ready", 16'(pwr_ready), 16'h0000);
      tick();
      psweep = 1'b0;
      pswp_val = 16'h0000;
      pwr_mode = 2'b11;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("swp_busy%0d", i), 16'(pbusy), 16'h0001);
         check($sformatf("swp_ready%0d", i), 16'(pwr_ready), 16'h0000);
         tick();
      end
      pwr_valid = 1'b0;
      check("swp_done_busy", 16'(pbusy), 16'h0000);
      check("swp_done_ready", 16'(pwr_ready), 16'h0001);
      for (int i = 0; i < 4; i++) rd(2'(i), 16'h5A5A, $sformatf("rd_swp%0d", i));
      // abort a sweep with reset in its second busy cycle
      psweep = 1'b1;
      pswp_val = 16'h1234;
      tick();
      psweep = 1'b0;
      tick();
      prst = 1'b1;
      #1;
      check("abort_busy", 16'(pbusy), 16'h0000);
      check("abort_ready", 16'(pwr_ready), 16'h0001);
      tick();
      prst = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) rd(2'(i), 16'hFFFF, $sformatf("rd_abort%0d", i));
      check("abort_end_busy", 16'(pbusy), 16'h0000);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
